// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state type and default datapath width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       MDOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             CancelE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] HIE,
    output logic [WIDTH-1:0] LOE
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = 2 * WIDTH;

    md_state_e state, state_n;

    logic [DW-1:0]    acc, acc_n;
    logic [WIDTH-1:0] opb, opb_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             neg_p, neg_p_n;
    logic             neg_r, neg_r_n;
    logic             dz, dz_n;
    logic             is_div, is_div_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] lo_q, lo_n;
    logic             done_q, done_n;

    logic             take;
    logic             sgn_op;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_t;
    logic             q_bit;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign take   = StartE && !CancelE;
    assign sgn_op = (MDOpE == OP_MULT) || (MDOpE == OP_DIV);
    assign sa     = SrcAE[WIDTH-1];
    assign sb     = SrcBE[WIDTH-1];
    assign mag_a  = (sgn_op && sa) ? -SrcAE : SrcAE;
    assign mag_b  = (sgn_op && sb) ? -SrcBE : SrcBE;
    assign last   = (cnt == CW'(WIDTH - 1));

    // Shared iteration arithmetic, selected by the current state.
    always_comb begin
        mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        rem_t    = acc[DW-1:WIDTH-1];
        q_bit    = 1'b0;
        if (rem_t >= {1'b0, opb}) begin
            rem_t = rem_t - {1'b0, opb};
            q_bit = 1'b1;
        end
        prod_fix = neg_p ? -acc : acc;
        quo_fix  = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            opb    <= opb_n;
            cnt    <= cnt_n;
            neg_p  <= neg_p_n;
            neg_r  <= neg_r_n;
            dz     <= dz_n;
            is_div <= is_div_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            done_q <= done_n;
        end
    end

    // Next-state: accept, iterate WIDTH times, fix up, or abort.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    if (MDOpE == OP_MULT || MDOpE == OP_MULTU)
                        state_n = ST_MUL;
                    else if (MDOpE == OP_DIV || MDOpE == OP_DIVU)
                        state_n = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (CancelE)
                    state_n = ST_IDLE;
                else if (last)
                    state_n = ST_FIX;
            end
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath and HI/LO updates for the current state.
    always_comb begin
        acc_n    = acc;
        opb_n    = opb;
        cnt_n    = cnt;
        neg_p_n  = neg_p;
        neg_r_n  = neg_r;
        dz_n     = dz;
        is_div_n = is_div;
        hi_n     = hi_q;
        lo_n     = lo_q;
        done_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    unique case (MDOpE)
                        OP_MULT, OP_MULTU: begin
                            acc_n    = {{WIDTH{1'b0}}, mag_b};
                            opb_n    = mag_a;
                            neg_p_n  = sgn_op && (sa ^ sb);
                            neg_r_n  = 1'b0;
                            dz_n     = 1'b0;
                            is_div_n = 1'b0;
                            cnt_n    = '0;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_n    = {{WIDTH{1'b0}}, mag_a};
                            opb_n    = mag_b;
                            neg_p_n  = sgn_op && (sa ^ sb);
                            neg_r_n  = sgn_op && sa;
                            dz_n     = (SrcBE == '0);
                            is_div_n = 1'b1;
                            cnt_n    = '0;
                        end
                        OP_MTHI: hi_n = SrcAE;
                        OP_MTLO: lo_n = SrcAE;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (!CancelE) begin
                    acc_n = {mul_sum, acc[WIDTH-1:1]};
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DIV: begin
                if (!CancelE) begin
                    acc_n = {rem_t[WIDTH-1:0], acc[WIDTH-2:0], q_bit};
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_FIX: begin
                if (!CancelE) begin
                    done_n = 1'b1;
                    if (!is_div) begin
                        hi_n = prod_fix[DW-1:WIDTH];
                        lo_n = prod_fix[WIDTH-1:0];
                    end else if (dz) begin
                        // Remainder magnitude equals |A|; restore the raw dividend.
                        hi_n = rem_fix;
                        lo_n = '1;
                    end else begin
                        hi_n = rem_fix;
                        lo_n = quo_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    assign BusyE = (state != ST_IDLE);
    assign DoneE = done_q;
    assign HIE   = hi_q;
    assign LOE   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the EX stage, driven by the ID/EX pipeline register outputs. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with forwarded operands and owns the architectural HI/LO registers. While an operation is in flight it raises `BusyE`, which the hazard logic uses to stall the IF/ID/EX stages.

## Interface
- `WIDTH`, default 32: operand width; HI/LO width; iteration count.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `StartE`  in  1: request valid this cycle; sampled only in IDLE.
- `MDOpE`  in  3: operation code; encodings are defined in `muldiv_pkg`.
- `SrcAE`  in  WIDTH: rs operand after forwarding (multiplicand, dividend, or MTHI/MTLO data).
- `SrcBE`  in  WIDTH: rt operand after forwarding (multiplier or divisor).
- `CancelE`  in  1: flush of the EX stage; aborts the request or the in-flight operation.
- `BusyE`  out  1: operation in flight; high whenever state is not IDLE.
- `DoneE`  out  1: one-cycle pulse on the edge that commits HI/LO from a mul/div.
- `HIE`  out  WIDTH: architectural HI register.
- `LOE`  out  WIDTH: architectural LO register.

## Operation
- Reset (asynchronous, `rst`=0): state IDLE, counter 0, `BusyE`=0, `DoneE`=0, `HIE`=0, `LOE`=0, all datapath registers 0.
- States:
  - IDLE: accepts requests.
  - MUL: shift-add multiply, WIDTH iterations.
  - DIV: restoring divide, WIDTH iterations.
  - FIX: sign correction and commit.
- IDLE with `StartE`=1 and `CancelE`=0:
  - MULT/MULTU → MUL.
  - DIV/DIVU → DIV.
  - On entry, capture operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - On entry, capture the result-sign flags: product negative = sign(A) XOR sign(B); remainder negative = sign(A).
  - Clear the counter.
- MTHI/MTLO in IDLE: write `SrcAE` to HI or LO at the same edge. Single cycle, no Busy, no `DoneE`.
- Undefined `MDOpE` codes: ignored, no state change.
- MUL and DIV perform one iteration per cycle. After the WIDTH-th iteration, go to FIX.
- FIX:
  - Apply 2's-complement negation per the sign flags.
  - Write HI/LO, pulse `DoneE`, return to IDLE.
- Multiply result: HI:LO = full 2·WIDTH-bit product.
- Divide result: LO = quotient, HI = remainder. The quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO = all ones, HI = `SrcAE` as captured. Sign correction is skipped.
- Signed DIV of the most negative value by −1: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- `StartE` while not IDLE: ignored. The pipeline is stalled, so the request is re-presented until accepted.
- `CancelE`=1 in any busy state: return to IDLE at the next edge, HI/LO unchanged, no `DoneE`.
- `CancelE` together with `StartE` in IDLE: cancel wins; nothing is accepted (this includes MTHI/MTLO).
- Reset mid-operation: the operation is abandoned immediately and all outputs take their reset values.

## Timing
- Accept edge N is the edge on which IDLE sees `StartE`.
- Iterations occur on edges N+1 through N+WIDTH. The FIX commit occurs on edge N+WIDTH+1.
- `BusyE` is high for WIDTH+1 cycles: from after edge N until edge N+WIDTH+1.
- `DoneE` is high for the single cycle following edge N+WIDTH+1. New HI/LO values are visible in that same cycle.
- A new request may be accepted on edge N+WIDTH+2, giving a back-to-back throughput of one op per WIDTH+2 cycles.
- `BusyE`, `DoneE`, `HIE` and `LOE` are all registered outputs; there is no combinational path from inputs.
- MFHI/MFLO consumers must read HI/LO only while `BusyE`=0. The hazard unit enforces this.

## Structure
- `muldiv_pkg` holds:
  - Op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - The state enum (IDLE/MUL/DIV/FIX).
  - A default-WIDTH constant.
- Single module, no sub-module. The shared datapath is one 2·WIDTH-bit accumulator/remainder register, one WIDTH-bit operand register, and a counter of $clog2(WIDTH)+1 bits.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `BusyE` high exactly 33 cycles; one `DoneE` pulse.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 ÷ 7 → LO=14, HI=2.
- Edge cases:
  - DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x1234 ÷ 0 → LO=0xFFFFFFFF, HI=0x1234.
- Cancel and start filtering:
  - Preload HI=0xAAAA via MTHI.
  - Start MULT; assert `CancelE` on iteration 10 → `BusyE` low next cycle, HI still 0xAAAA, no `DoneE`.
  - MTLO presented while busy → LO unchanged.
- Assert `rst` low at iteration 20 of a DIV → `BusyE`, `DoneE`, `HIE` and `LOE` go to 0 immediately. After release, MULTU 2×3 → LO=6 after 33 busy cycles.
